// File: rtl/console_pkg.sv
// Shared definitions for the character-console path: FSM states, control
// codes and the default screen geometry (also used by the LCD scan-out).
package console_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_CLEAR,
    ST_SCROLL_RD,
    ST_SCROLL_WR,
    ST_SCROLL_CLR
  } state_t;

  localparam logic [7:0] CC_CR    = 8'h0D;
  localparam logic [7:0] CC_LF    = 8'h0A;
  localparam logic [7:0] CC_BS    = 8'h08;
  localparam logic [7:0] CC_FF    = 8'h0C;
  localparam logic [7:0] CC_SPACE = 8'h20;

  localparam int unsigned DEF_STRIDE = 108;
  localparam int unsigned DEF_VCOLS  = 106;
  localparam int unsigned DEF_ROWS   = 36;
  localparam logic [7:0]  DEF_FILL   = 8'h20;

endpackage

// File: rtl/console_cursor.sv
// Cursor tracker: keeps row, column and the row base address so the linear
// cursor address is a single add (rowbase + col), no multiplier.
module console_cursor
  import console_pkg::*;
#(
  parameter int unsigned STRIDE = DEF_STRIDE,
  parameter int unsigned VCOLS  = DEF_VCOLS,
  parameter int unsigned ROWS   = DEF_ROWS
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        home,
  input  logic        cr,
  input  logic        lf,
  input  logic        bs,
  input  logic        advance,
  output logic [11:0] o_cursor,
  output logic        at_last_row,
  output logic        wrap
);

  localparam logic [11:0] STEP     = 12'(STRIDE);
  localparam logic [6:0]  COL_LAST = 7'(VCOLS - 1);
  localparam logic [5:0]  ROW_LAST = 6'(ROWS - 1);

  logic [11:0] rowbase;
  logic [6:0]  col;
  logic [5:0]  row;

  assign at_last_row = (row == ROW_LAST);
  assign wrap        = (col == COL_LAST);
  assign o_cursor    = rowbase + {5'd0, col};

  // Cursor update; on the last row a line feed leaves the row alone because
  // the screen contents move up instead.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rowbase <= '0;
      col     <= '0;
      row     <= '0;
    end else if (home) begin
      rowbase <= '0;
      col     <= '0;
      row     <= '0;
    end else if (cr) begin
      col <= '0;
    end else if (lf || (advance && wrap)) begin
      if (advance) col <= '0;
      if (!at_last_row) begin
        row     <= row + 6'd1;
        rowbase <= rowbase + STEP;
      end
    end else if (bs) begin
      if (col != '0) col <= col - 7'd1;
    end else if (advance) begin
      col <= col + 7'd1;
    end
  end

endmodule

// File: rtl/console_writer.sv
// Text-console writer: takes bytes over valid/ready, handles CR/LF/BS/FF,
// writes printable characters to video RAM and does clear/scroll by
// sweeping or copying RAM contents.
module console_writer
  import console_pkg::*;
#(
  parameter int unsigned STRIDE = DEF_STRIDE,
  parameter int unsigned VCOLS  = DEF_VCOLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter logic [7:0]  FILL   = DEF_FILL
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_char,
  input  logic        i_valid,
  output logic        o_ready,
  output logic [11:0] o_waddr,
  output logic [7:0]  o_wdata,
  output logic        o_we,
  output logic [11:0] o_raddr,
  input  logic [7:0]  i_rdata,
  output logic [11:0] o_cursor
);

  localparam logic [11:0] STEP      = 12'(STRIDE);
  localparam logic [11:0] CELL_LAST = 12'(ROWS * STRIDE - 1);
  localparam logic [11:0] COPY_LAST = 12'((ROWS - 1) * STRIDE - 1);

  generate
    if (ROWS * STRIDE > 4096 || VCOLS > STRIDE || VCOLS > 127 || ROWS > 64
        || ROWS < 2) begin : g_geom_check
      $error("console_writer: geometry does not fit the 4096-cell video RAM");
    end
  endgenerate

  state_t      state;
  logic [11:0] cnt;
  logic        accept;
  logic        is_print;
  logic        cur_home, cur_cr, cur_lf, cur_bs, cur_adv;
  logic        at_last_row, wrap;

  // Decode the accepted byte into cursor operations.
  always_comb begin
    accept   = i_valid && (state == ST_IDLE);
    is_print = (i_char >= CC_SPACE);
    cur_cr   = accept && (i_char == CC_CR);
    cur_lf   = accept && (i_char == CC_LF);
    cur_bs   = accept && (i_char == CC_BS);
    cur_adv  = (state == ST_WRITE);
    cur_home = (state == ST_CLEAR) && (cnt == CELL_LAST);
  end

  console_cursor #(
    .STRIDE(STRIDE),
    .VCOLS (VCOLS),
    .ROWS  (ROWS)
  ) u_cursor (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .home       (cur_home),
    .cr         (cur_cr),
    .lf         (cur_lf),
    .bs         (cur_bs),
    .advance    (cur_adv),
    .o_cursor   (o_cursor),
    .at_last_row(at_last_row),
    .wrap       (wrap)
  );

  // Main FSM with registered RAM-port and handshake outputs. The scroll copy
  // registers i_rdata in SCROLL_WR, so each copy write lands during the next
  // SCROLL_RD while the following read is already on o_raddr.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state   <= ST_CLEAR;
      cnt     <= '0;
      o_ready <= 1'b0;
      o_we    <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
      o_raddr <= '0;
    end else begin
      o_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (i_char == CC_FF) begin
              state   <= ST_CLEAR;
              cnt     <= '0;
              o_ready <= 1'b0;
            end else if (i_char == CC_LF && at_last_row) begin
              state   <= ST_SCROLL_RD;
              cnt     <= '0;
              o_raddr <= STEP;
              o_ready <= 1'b0;
            end else if (is_print) begin
              state   <= ST_WRITE;
              o_ready <= 1'b0;
              o_we    <= 1'b1;
              o_waddr <= o_cursor;
              o_wdata <= i_char;
            end
          end
        end
        ST_WRITE: begin
          if (wrap && at_last_row) begin
            state   <= ST_SCROLL_RD;
            cnt     <= '0;
            o_raddr <= STEP;
          end else begin
            state   <= ST_IDLE;
            o_ready <= 1'b1;
          end
        end
        ST_CLEAR: begin
          o_we    <= 1'b1;
          o_waddr <= cnt;
          o_wdata <= FILL;
          if (cnt == CELL_LAST) begin
            state   <= ST_IDLE;
            o_ready <= 1'b1;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        ST_SCROLL_RD: begin
          state <= ST_SCROLL_WR;
        end
        ST_SCROLL_WR: begin
          o_we    <= 1'b1;
          o_waddr <= cnt;
          o_wdata <= i_rdata;
          cnt     <= cnt + 12'd1;
          if (cnt == COPY_LAST) begin
            state <= ST_SCROLL_CLR;
          end else begin
            state   <= ST_SCROLL_RD;
            o_raddr <= cnt + STEP + 12'd1;
          end
        end
        ST_SCROLL_CLR: begin
          o_we    <= 1'b1;
          o_waddr <= cnt;
          o_wdata <= FILL;
          if (cnt == CELL_LAST) begin
            state   <= ST_IDLE;
            o_ready <= 1'b1;
          end else begin
            cnt <= cnt + 12'd1;
          end
        end
        default: begin
          state   <= ST_CLEAR;
          cnt     <= '0;
          o_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_console_writer.sv
// Self-checking bench for console_writer: a screen-level reference model
// predicts every RAM write (scoreboard queue), handshake busy time and cursor.
module tb_console_writer;

  localparam int STRIDE     = 108;
  localparam int VCOLS      = 106;
  localparam int ROWS       = 36;
  localparam logic [7:0] FILL = 8'h20;
  localparam int CELLS      = ROWS * STRIDE;
  localparam int COPY       = (ROWS - 1) * STRIDE;
  localparam int SCROLL_CYC = 2 * COPY + STRIDE;
  localparam int CLEAR_CYC  = CELLS;
  localparam int BOUND      = 20000;

  logic        i_clk   = 1'b0;
  logic        i_reset = 1'b0;
  logic [7:0]  i_char  = 8'h00;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [11:0] o_waddr;
  logic [7:0]  o_wdata;
  logic        o_we;
  logic [11:0] o_raddr;
  logic [7:0]  i_rdata;
  logic [11:0] o_cursor;

  always #5 i_clk = ~i_clk;

  console_writer #(
    .STRIDE(STRIDE),
    .VCOLS (VCOLS),
    .ROWS  (ROWS),
    .FILL  (FILL)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_char  (i_char),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_waddr (o_waddr),
    .o_wdata (o_wdata),
    .o_we    (o_we),
    .o_raddr (o_raddr),
    .i_rdata (i_rdata),
    .o_cursor(o_cursor)
  );

  // Video RAM: synchronous write, one-cycle read latency.
  logic [7:0] ram [0:4095];
  always @(posedge i_clk) begin
    if (o_we) ram[o_waddr] <= o_wdata;
    i_rdata <= ram[o_raddr];
  end

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] scr [0:4095];
  int         mrow = 0;
  int         mcol = 0;
  int         total = 0;
  int         bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (screen level) ----------------
  function automatic void push_wr(input int a, input logic [7:0] d);
    wr_t w;
    w.a = 12'(a);
    w.d = d;
    exp_q.push_back(w);
    scr[a] = d;
  endfunction

  function automatic void model_clear();
    for (int a = 0; a < CELLS; a++) push_wr(a, FILL);
    mrow = 0;
    mcol = 0;
  endfunction

  function automatic void model_newline(inout int busy);
    if (mrow < ROWS - 1) begin
      mrow++;
    end else begin
      for (int a = 0; a < COPY; a++) push_wr(a, scr[a + STRIDE]);
      for (int a = COPY; a < CELLS; a++) push_wr(a, FILL);
      busy += SCROLL_CYC;
    end
  endfunction

  function automatic int model_byte(input logic [7:0] b);
    int busy = 0;
    if (b == 8'h0D) mcol = 0;
    else if (b == 8'h0A) model_newline(busy);
    else if (b == 8'h08) begin
      if (mcol > 0) mcol--;
    end else if (b == 8'h0C) begin
      model_clear();
      busy = CLEAR_CYC;
    end else if (b >= 8'h20) begin
      push_wr(mrow * STRIDE + mcol, b);
      busy = 1;
      mcol++;
      if (mcol == VCOLS) begin
        mcol = 0;
        model_newline(busy);
      end
    end
    return busy;
  endfunction

  // ---------------- write monitor ----------------
  always @(negedge i_clk) begin
    if (i_reset && o_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write: got addr=%0d data=%02h expected no write", o_waddr, o_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (o_waddr !== e.a || o_wdata !== e.d) begin
          bad++;
          $display("FAIL write: got addr=%0d data=%02h expected addr=%0d data=%02h",
                   o_waddr, o_wdata, e.a, e.d);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < BOUND) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int exp_busy;
    int busy = 0;
    wait_ready();
    i_char  = b;
    i_valid = 1'b1;
    exp_busy = model_byte(b);
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_ready || busy > BOUND) break;
      busy++;
    end
    check("busy_cycles", busy, exp_busy);
    check("cursor", int'(o_cursor), mrow * STRIDE + mcol);
  endtask

  task automatic release_reset();
    int n = 0;
    model_clear();
    @(negedge i_clk);
    i_reset = 1'b1;
    forever begin
      @(negedge i_clk);
      n++;
      if (o_ready || n > BOUND) break;
    end
    check("clear_cycles", n, CLEAR_CYC);
    check("cursor_after_clear", int'(o_cursor), 0);
  endtask

  function automatic int ram_mismatches();
    int m = 0;
    for (int a = 0; a < CELLS; a++) if (ram[a] !== scr[a]) m++;
    return m;
  endfunction

  initial begin
    logic [7:0] ign [5];
    ign[0] = 8'h00; ign[1] = 8'h01; ign[2] = 8'h07; ign[3] = 8'h1B; ign[4] = 8'h1F;

    // Reset values
    repeat (3) @(negedge i_clk);
    check("reset_ready", int'(o_ready), 0);
    check("reset_we", int'(o_we), 0);
    check("reset_waddr", int'(o_waddr), 0);
    check("reset_wdata", int'(o_wdata), 0);
    check("reset_raddr", int'(o_raddr), 0);
    check("reset_cursor", int'(o_cursor), 0);

    // Clear after reset release
    release_reset();

    // Single printable character
    send_byte(8'h41);
    check("A_cursor", int'(o_cursor), 1);

    // CR / LF / BS
    send_byte(8'h41);
    send_byte(8'h42);
    send_byte(8'h08);
    send_byte(8'h0D);
    send_byte(8'h0A);
    send_byte(8'h43);
    check("crlf_cursor", int'(o_cursor), 109);

    // Form feed, then wrap at the end of row 0
    send_byte(8'h0C);
    for (int i = 0; i < VCOLS; i++) send_byte(8'h58);
    check("wrap_cursor", int'(o_cursor), 108);

    // Fill row 1, go to the last row, scroll
    for (int i = 0; i < VCOLS; i++) send_byte(8'h31);
    for (int i = 0; i < ROWS - 3; i++) send_byte(8'h0A);
    check("last_row_cursor", int'(o_cursor), 3780);
    send_byte(8'h0A);
    check("scroll_cursor", int'(o_cursor), 3780);
    @(negedge i_clk);
    check("scroll_ram_vs_model", ram_mismatches(), 0);
    check("scroll_ram_0", int'(ram[0]), 8'h31);
    check("scroll_ram_105", int'(ram[105]), 8'h31);
    check("scroll_ram_3780", int'(ram[3780]), 8'h20);
    check("scroll_ram_3887", int'(ram[3887]), 8'h20);

    // Random byte stream
    send_byte(8'h0C);
    for (int i = 0; i < 200; i++) begin
      int r;
      logic [7:0] b;
      r = int'($urandom_range(0, 99));
      if (r < 5) b = 8'h0A;
      else if (r < 8) b = 8'h0D;
      else if (r < 11) b = 8'h08;
      else if (r < 14) b = ign[$urandom_range(0, 4)];
      else b = 8'($urandom_range(32, 255));
      send_byte(b);
    end
    @(negedge i_clk);
    check("random_ram_vs_model", ram_mismatches(), 0);

    // Reset in the middle of a scroll
    send_byte(8'h0C);
    for (int i = 0; i < ROWS - 1; i++) send_byte(8'h0A);
    wait_ready();
    i_char  = 8'h0A;
    i_valid = 1'b1;
    void'(model_byte(8'h0A));
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    repeat (100) @(negedge i_clk);
    check("midscroll_ready", int'(o_ready), 0);
    check("midscroll_cursor", int'(o_cursor), 3780);
    i_reset = 1'b0;
    #1;
    check("abort_we", int'(o_we), 0);
    check("abort_ready", int'(o_ready), 0);
    check("abort_waddr", int'(o_waddr), 0);
    check("abort_cursor", int'(o_cursor), 0);
    exp_q.delete();
    repeat (2) @(negedge i_clk);
    release_reset();

    repeat (3) @(negedge i_clk);
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
